// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Op and state encodings, memory-port strobe levels, and op classification helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OpLw  = 3'b000,
        OpLh  = 3'b001,
        OpLhu = 3'b010,
        OpLb  = 3'b011,
        OpLbu = 3'b100,
        OpSw  = 3'b101,
        OpSh  = 3'b110,
        OpSb  = 3'b111
    } mem_op_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StRmwWr = 1'b1
    } state_e;

    localparam logic        RAM_ENABLE  = 1'b1;
    localparam logic        RAM_DISABLE = 1'b0;
    localparam logic        RAM_WRITE   = 1'b1;
    localparam logic        RAM_READ    = 1'b0;
    localparam logic [31:0] ZERO        = 32'h0000_0000;

    function automatic logic is_load(mem_op_e op);
        return op inside {OpLw, OpLh, OpLhu, OpLb, OpLbu};
    endfunction

    function automatic logic is_word(mem_op_e op);
        return op inside {OpLw, OpSw};
    endfunction

    function automatic logic is_half(mem_op_e op);
        return op inside {OpLh, OpLhu, OpSh};
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: loads extract and extend a lane from a word, SH/SB merge new
// data into the old word. The op alone picks which of the two functions applies.
module lane_align
    import mem_access_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        result   = word;
        unique case (op)
            OpLw, OpSw: result = word;
            OpLh:       result = {{16{half_sel[15]}}, half_sel};
            OpLhu:      result = {16'h0000, half_sel};
            OpLb:       result = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:      result = {24'h00_0000, byte_sel};
            OpSh:       result[{addr_lo[1], 4'b0000} +: 16] = wdata;
            OpSb:       result[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: loads and SW take one cycle, SH/SB read-modify-write.
// Define MISALIGN_EXC_EN to flag misaligned accesses instead of forcing alignment.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              stall,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef MISALIGN_EXC_EN
   ,output logic              misalign_err
`endif
);

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_op_e           op_q, op_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [15:0]       wdata_q, wdata_d;

    mem_op_e           op;
    logic [ADDR_W-1:0] addr_eff;
    logic              misaligned;
    logic              accept;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    assign op        = mem_op_e'(req_op);
    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef MISALIGN_EXC_EN
    logic misalign_q, misalign_d;
    assign misaligned   = (is_word(op) && (req_addr[1:0] != 2'b00)) || (is_half(op) && req_addr[0]);
    assign addr_eff     = req_addr;
    assign misalign_err = misalign_q;
`else
    assign misaligned = 1'b0;
    always_comb begin
        addr_eff = req_addr;
        if (is_word(op)) begin
            addr_eff[1:0] = 2'b00;
        end else if (is_half(op)) begin
            addr_eff[0] = 1'b0;
        end
    end
`endif

    lane_align u_load_align (
        .op      (op),
        .addr_lo (addr_eff[1:0]),
        .word    (ram_rdata),
        .wdata   (16'h0000),
        .result  (load_data)
    );

    lane_align u_store_merge (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .word    (old_q),
        .wdata   (wdata_q),
        .result  (merge_data)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = ZERO;
        addr_d       = addr_q;
        op_d         = op_q;
        old_d        = old_q;
        wdata_d      = wdata_q;
`ifdef MISALIGN_EXC_EN
        misalign_d   = 1'b0;
`endif
        ram_ce       = RAM_DISABLE;
        ram_we       = RAM_READ;
        ram_addr     = '0;
        ram_wdata    = ZERO;
        stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (misaligned) begin
                        resp_valid_d = 1'b1;
`ifdef MISALIGN_EXC_EN
                        misalign_d   = 1'b1;
`endif
                    end else begin
                        ram_ce   = RAM_ENABLE;
                        ram_addr = addr_eff;
                        if (is_load(op)) begin
                            resp_valid_d = 1'b1;
                            resp_rdata_d = load_data;
                        end else if (op == OpSw) begin
                            ram_we       = RAM_WRITE;
                            ram_wdata    = req_wdata;
                            resp_valid_d = 1'b1;
                        end else begin
                            // Read half of SH/SB: capture the old word for the merge.
                            stall   = 1'b1;
                            addr_d  = addr_eff;
                            op_d    = op;
                            old_d   = ram_rdata;
                            wdata_d = req_wdata[15:0];
                            state_d = StRmwWr;
                        end
                    end
                end
            end
            StRmwWr: begin
                ram_ce       = RAM_ENABLE;
                ram_we       = RAM_WRITE;
                ram_addr     = addr_q;
                ram_wdata    = merge_data;
                stall        = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset must suppress a pending RMW write as well as idle-cycle outputs.
        if (rst) begin
            ram_ce    = RAM_DISABLE;
            ram_we    = RAM_READ;
            ram_addr  = '0;
            ram_wdata = ZERO;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= ZERO;
            addr_q       <= '0;
            op_q         <= OpLw;
            old_q        <= ZERO;
            wdata_q      <= 16'h0000;
`ifdef MISALIGN_EXC_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            old_q        <= old_d;
            wdata_q      <= wdata_d;
`ifdef MISALIGN_EXC_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences, random traffic
// against a byte-array memory model. Builds with or without MISALIGN_EXC_EN.
module tb_mem_access_unit;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall, ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef MISALIGN_EXC_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .stall      (stall),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef MISALIGN_EXC_EN
       ,.misalign_err (misalign_err)
`endif
    );

    // Word memory seen by the DUT; preload port shares the single write process.
    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] last_wr_addr, last_wr_data;
    int          we_cnt = 0, ce_cnt = 0, stall_cnt = 0;

    assign ram_rdata = mem[ram_addr[11:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (ram_ce && ram_we) begin
            mem[ram_addr[11:2]] <= ram_wdata;
            last_wr_addr        <= ram_addr;
            last_wr_data        <= ram_wdata;
        end
    end

    always @(negedge clk) begin
        if (ram_ce) ce_cnt <= ce_cnt + 1;
        if (ram_ce && ram_we) we_cnt <= we_cnt + 1;
        if (stall) stall_cnt <= stall_cnt + 1;
    end

    // Reference model: little-endian byte-addressed storage.
    logic [7:0] ref_b [0:4095];
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = addr[11:2];
        pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[{addr[11:2], 2'b00} + k] = data[8*k +: 8];
    endtask

    function automatic logic [31:0] eff(input logic [2:0] op, input logic [31:0] a);
`ifdef MISALIGN_EXC_EN
        return a;
`else
        if (op == LW || op == SW) return a & ~32'h3;
        if (op == LH || op == LHU || op == SH) return a & ~32'h1;
        return a;
`endif
    endfunction

    function automatic logic misal(input logic [2:0] op, input logic [31:0] a);
`ifdef MISALIGN_EXC_EN
        return ((op == LW || op == SW) && a[1:0] != 2'b00) ||
               ((op == LH || op == LHU || op == SH) && a[0]);
`else
        return (op == 3'd0) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output logic err);
        int b;
        logic [15:0] h;
        logic [7:0] y;
        err = misal(op, a);
        rd  = 32'h0;
        lat = 1;
        if (err) return;
        b = int'(eff(op, a) & 32'hFFF);
        h = {ref_b[b+1], ref_b[b]};
        y = ref_b[b];
        case (op)
            LW:  rd = {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
            LH:  rd = (h >= 16'h8000) ? 32'(h) - 32'h1_0000 : 32'(h);
            LHU: rd = 32'(h);
            LB:  rd = (y >= 8'h80) ? 32'(y) - 32'h100 : 32'(y);
            LBU: rd = 32'(y);
            SW:  for (int k = 0; k < 4; k++) ref_b[b+k] = wd[8*k +: 8];
            SH:  begin ref_b[b] = wd[7:0]; ref_b[b+1] = wd[15:8]; lat = 2; end
            default: begin ref_b[b] = wd[7:0]; lat = 2; end
        endcase
    endtask

    // Present a request, wait for acceptance and the response pulse (both bounded).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output logic err);
        int guard = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
        rd = resp_rdata;
`ifdef MISALIGN_EXC_EN
        err = misalign_err;
`else
        err = 1'b0;
`endif
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] erd;
        int elat, lat;
        logic eerr, err;
        model(op, a, wd, erd, elat, eerr);
        issue(op, a, wd, rd, lat, err);
        chk({name, "_rdata"}, rd, erd);
        chk({name, "_latency"}, lat, elat);
`ifdef MISALIGN_EXC_EN
        chk({name, "_misalign_err"}, {31'b0, err}, {31'b0, eerr});
`else
        if (err !== eerr) chk({name, "_err"}, {31'b0, err}, {31'b0, eerr});
`endif
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] rd;
        int lat, snap_we, snap_stall, snap_ce;
        logic err;

        vecs[0] = '{LB,  32'h10, 32'hFFFF_FF80, 1};
        vecs[1] = '{LBU, 32'h10, 32'h0000_0080, 1};
        vecs[2] = '{LB,  32'h11, 32'h0000_007F, 1};
        vecs[3] = '{LH,  32'h12, 32'hFFFF_8081, 1};
        vecs[4] = '{LHU, 32'h12, 32'h0000_8081, 1};
        vecs[5] = '{LW,  32'h10, 32'h8081_7F80, 1};

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;

        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        preload(32'h10, 32'h8081_7F80);
        preload(32'h30, 32'h1122_3344);
        preload(32'h40, 32'hCAFE_F00D);

        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].op, vecs[i].addr, 32'h0, rd, lat, err);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // SW then LW issued back-to-back.
        snap_we = we_cnt;
        run("sw_20", SW, 32'h20, 32'hDEAD_BEEF, rd);
        run("lw_20", LW, 32'h20, 32'h0, rd);
        chk("lw_20_after_sw", rd, 32'hDEAD_BEEF);
        chk("sw_we_cycles", we_cnt - snap_we, 1);

        // Sub-word stores: two stall cycles and one merged write each.
        snap_we = we_cnt;
        snap_stall = stall_cnt;
        run("sb_31", SB, 32'h31, 32'h0000_00AA, rd);
        chk("sb_stall_cycles", stall_cnt - snap_stall, 2);
        chk("sb_we_cycles", we_cnt - snap_we, 1);
        chk("sb_write_data", last_wr_data, 32'h1122_AA44);
        chk("sb_write_word", last_wr_addr & ~32'h3, 32'h30);
        run("sh_32", SH, 32'h32, 32'h0000_5566, rd);
        chk("sh_write_data", last_wr_data, 32'h5566_AA44);

        // Reset while the SB at 0x40 is in its write half.
        snap_we = we_cnt;
        req_valid = 1'b1;
        req_op = SB;
        req_addr = 32'h40;
        req_wdata = 32'h0000_0011;
        @(negedge clk);
        chk("rmw_rst_accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rmw_rst_ram_ce", {31'b0, ram_ce}, 32'd0);
        chk("rmw_rst_stall", {31'b0, stall}, 32'd0);
        chk("rmw_rst_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmw_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rmw_rst_resp_rdata", resp_rdata, 32'h0);
        chk("rmw_rst_ready_after", {31'b0, req_ready}, 32'd1);
        chk("rmw_rst_ram_addr", ram_addr, 32'h0);
        chk("rmw_rst_no_write", we_cnt - snap_we, 0);
        chk("rmw_rst_mem_40", mem[32'h40 >> 2], 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Misaligned word load.
        snap_ce = ce_cnt;
        run("lw_42", LW, 32'h42, 32'h0, rd);
`ifdef MISALIGN_EXC_EN
        chk("lw_42_no_ce", ce_cnt - snap_ce, 0);
        chk("lw_42_rdata_zero", rd, 32'h0);
`else
        chk("lw_42_ce_cycles", ce_cnt - snap_ce, 1);
        chk("lw_42_aligned_word", rd, 32'hCAFE_F00D);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run("rand", op, 32'($urandom_range(0, 255)), $urandom, rd);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("mem_final_%0d", i), mem[i],
                {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
